// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline hazard logic.
// Also hosts the mult/div encodings used by the decoders.
package pipe_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // Producer result arrives later than the consumer needs it.
  function automatic logic grf_hazard(
    input logic [4:0] a,
    input logic [4:0] a3,
    input logic       we,
    input logic [1:0] tnew,
    input logic [1:0] tuse
  );
    return (a != REG_ZERO) && we &&
           (a3 == a) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/md_busy_seq.sv
// Mult/div busy sequencer: loads a cycle count on start,
// counts down to zero, busy while the count is nonzero.
module md_busy_seq
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  md_state_t      state, state_n;
  logic [CW-1:0]  cnt, cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // A start while busy simply reloads from the new op.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (start) begin
      state_n = MD_BUSY;
      cnt_n   = is_div ? CW'(DIV_CYCLES)
                       : CW'(MULT_CYCLES);
    end else if (state == MD_BUSY) begin
      cnt_n = cnt - CW'(1);
      if (cnt == CW'(1)) state_n = MD_IDLE;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: Tuse/Tnew compare plus mult/div
// busy, drives stage enables and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       A1_D,
  input  logic [4:0]       A2_D,
  input  logic [1:0]       Tuse_rs_D,
  input  logic [1:0]       Tuse_rt_D,
  input  logic             MD_D,
  input  logic [4:0]       A3_E,
  input  logic             WE_E,
  input  logic [1:0]       Tnew_E,
  input  logic             MD_START_E,
  input  logic             MD_IS_DIV_E,
  input  logic [4:0]       A3_M,
  input  logic             WE_M,
  input  logic [1:0]       Tnew_M,
  output logic             en_PC,
  output logic             en_FD,
  output logic             flush_DE,
  output logic             en_DE,
  output logic             en_EM,
  output logic             en_MW,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic stall_rs, stall_rt, stall_md, stall;

  md_busy_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk    (clk),
    .rst    (rst),
    .start  (MD_START_E),
    .is_div (MD_IS_DIV_E),
    .busy   (md_busy)
  );

  assign stall_rs =
    grf_hazard(A1_D, A3_E, WE_E, Tnew_E, Tuse_rs_D) |
    grf_hazard(A1_D, A3_M, WE_M, Tnew_M, Tuse_rs_D);

  assign stall_rt =
    grf_hazard(A2_D, A3_E, WE_E, Tnew_E, Tuse_rt_D) |
    grf_hazard(A2_D, A3_M, WE_M, Tnew_M, Tuse_rt_D);

  assign stall_md = MD_D & (md_busy | MD_START_E);
  assign stall    = stall_rs | stall_rt | stall_md;

  // Stalled D holds; DE takes a bubble; back end drains.
  assign en_PC    = ~stall;
  assign en_FD    = ~stall;
  assign flush_DE = stall;
  assign en_DE    = 1'b1;
  assign en_EM    = 1'b1;
  assign en_MW    = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a narrow stall
// counter so saturation is reachable.
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;
  localparam logic [5:0] RUN  = 6'b110111;
  localparam logic [5:0] HOLD = 6'b001111;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    A1_D, A2_D, A3_E, A3_M;
  logic [1:0]    Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
  logic          MD_D, WE_E, MD_START_E, MD_IS_DIV_E, WE_M;
  logic          en_PC, en_FD, flush_DE, en_DE, en_EM, en_MW;
  logic          md_busy;
  logic [CW-1:0] stall_cnt;
  logic [5:0]    outs;

  int n_checks = 0;
  int n_fail   = 0;

  assign outs = {en_PC, en_FD, flush_DE, en_DE, en_EM, en_MW};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .A1_D        (A1_D),
    .A2_D        (A2_D),
    .Tuse_rs_D   (Tuse_rs_D),
    .Tuse_rt_D   (Tuse_rt_D),
    .MD_D        (MD_D),
    .A3_E        (A3_E),
    .WE_E        (WE_E),
    .Tnew_E      (Tnew_E),
    .MD_START_E  (MD_START_E),
    .MD_IS_DIV_E (MD_IS_DIV_E),
    .A3_M        (A3_M),
    .WE_M        (WE_M),
    .Tnew_M      (Tnew_M),
    .en_PC       (en_PC),
    .en_FD       (en_FD),
    .flush_DE    (flush_DE),
    .en_DE       (en_DE),
    .en_EM       (en_EM),
    .en_MW       (en_MW),
    .md_busy     (md_busy),
    .stall_cnt   (stall_cnt)
  );

  task automatic idle_inputs();
    A1_D = 5'd0; A2_D = 5'd0;
    Tuse_rs_D = 2'd3; Tuse_rt_D = 2'd3;
    MD_D = 1'b0;
    A3_E = 5'd0; WE_E = 1'b0; Tnew_E = 2'd0;
    MD_START_E = 1'b0; MD_IS_DIV_E = 1'b0;
    A3_M = 5'd0; WE_M = 1'b0; Tnew_M = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    n_checks++;
    if (outs !== RUN) begin
      n_fail++;
      $display("FAIL reset_outs got %b want %b", outs, RUN);
    end
    n_checks++;
    if (md_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", md_busy);
    end
    n_checks++;
    if (stall_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got %0d want 0", stall_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle_inputs();
    WE_E = 1'b1; A3_E = 5'd2; Tnew_E = 2'd2;
    A1_D = 5'd2; Tuse_rs_D = 2'd1;
    #2;
    n_checks++;
    if (outs !== HOLD) begin
      n_fail++;
      $display("FAIL lu_stall got %b want %b", outs, HOLD);
    end
    @(negedge clk);
    WE_E = 1'b0;
    WE_M = 1'b1; A3_M = 5'd2; Tnew_M = 2'd1;
    #2;
    n_checks++;
    if (outs !== RUN) begin
      n_fail++;
      $display("FAIL lu_release got %b want %b", outs, RUN);
    end
    n_checks++;
    if (stall_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL lu_cnt got %0d want 1", stall_cnt);
    end
  endtask

  task automatic test_reg_zero();
    @(negedge clk);
    idle_inputs();
    WE_E = 1'b1; A3_E = 5'd0; Tnew_E = 2'd2;
    A1_D = 5'd0; Tuse_rs_D = 2'd1;
    A2_D = 5'd0; Tuse_rt_D = 2'd0;
    #2;
    n_checks++;
    if (outs !== RUN) begin
      n_fail++;
      $display("FAIL r0_outs got %b want %b", outs, RUN);
    end
    @(negedge clk);
    idle_inputs();
    #2;
    n_checks++;
    if (stall_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL r0_cnt got %0d want 1", stall_cnt);
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    idle_inputs();
    WE_E = 1'b1; A3_E = 5'd5; Tnew_E = 2'd1;
    A1_D = 5'd5; Tuse_rs_D = 2'd0;
    #2;
    n_checks++;
    if (outs !== HOLD) begin
      n_fail++;
      $display("FAIL br_stall got %b want %b", outs, HOLD);
    end
    @(negedge clk);
    WE_E = 1'b0;
    WE_M = 1'b1; A3_M = 5'd5; Tnew_M = 2'd0;
    #2;
    n_checks++;
    if (outs !== RUN) begin
      n_fail++;
      $display("FAIL br_release got %b want %b", outs, RUN);
    end
    n_checks++;
    if (stall_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL br_cnt got %0d want 2", stall_cnt);
    end
  endtask

  task automatic test_rt_m_stage();
    @(negedge clk);
    idle_inputs();
    WE_M = 1'b1; A3_M = 5'd7; Tnew_M = 2'd1;
    A2_D = 5'd7; Tuse_rt_D = 2'd3;
    #2;
    n_checks++;
    if (outs !== RUN) begin
      n_fail++;
      $display("FAIL rt_unused got %b want %b", outs, RUN);
    end
    @(negedge clk);
    Tuse_rt_D = 2'd0;
    #2;
    n_checks++;
    if (outs !== HOLD) begin
      n_fail++;
      $display("FAIL rt_stall got %b want %b", outs, HOLD);
    end
    @(negedge clk);
    idle_inputs();
    #2;
    n_checks++;
    if (stall_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL rt_cnt got %0d want 3", stall_cnt);
    end
  endtask

  task automatic test_div_stall();
    @(negedge clk);
    idle_inputs();
    MD_START_E = 1'b1; MD_IS_DIV_E = 1'b1; MD_D = 1'b1;
    #2;
    n_checks++;
    if (outs !== HOLD || md_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL div_c0 got %b/%b want %b/0",
               outs, md_busy, HOLD);
    end
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      MD_START_E = 1'b0; MD_IS_DIV_E = 1'b0;
      #2;
      n_checks++;
      if (md_busy !== (c <= 10) ||
          outs !== ((c <= 10) ? HOLD : RUN)) begin
        n_fail++;
        $display("FAIL div_c%0d got %b/%b want %b/%b",
                 c, outs, md_busy,
                 (c <= 10) ? HOLD : RUN, c <= 10);
      end
    end
    n_checks++;
    if (stall_cnt !== 4'd14) begin
      n_fail++;
      $display("FAIL div_cnt got %0d want 14", stall_cnt);
    end
  endtask

  task automatic test_mult_nostall();
    @(negedge clk);
    idle_inputs();
    MD_START_E = 1'b1; MD_IS_DIV_E = 1'b0;
    #2;
    n_checks++;
    if (outs !== RUN || md_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_c0 got %b/%b want %b/0",
               outs, md_busy, RUN);
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      MD_START_E = 1'b0;
      #2;
      n_checks++;
      if (md_busy !== (c <= 5) || outs !== RUN) begin
        n_fail++;
        $display("FAIL mul_c%0d got %b/%b want %b/%b",
                 c, outs, md_busy, RUN, c <= 5);
      end
    end
    n_checks++;
    if (stall_cnt !== 4'd14) begin
      n_fail++;
      $display("FAIL mul_cnt got %0d want 14", stall_cnt);
    end
  endtask

  task automatic test_saturate();
    logic [CW-1:0] exp_cnt;
    exp_cnt = 4'd14;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle_inputs();
      WE_E = 1'b1; A3_E = 5'd3; Tnew_E = 2'd2;
      A1_D = 5'd3; Tuse_rs_D = 2'd0;
      #2;
      n_checks++;
      if (stall_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL sat_c%0d got %0d want %0d",
                 c, stall_cnt, exp_cnt);
      end
      exp_cnt = 4'd15;
    end
    @(negedge clk);
    idle_inputs();
    #2;
    n_checks++;
    if (stall_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_end got %0d want 15", stall_cnt);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    idle_inputs();
    MD_START_E = 1'b1; MD_IS_DIV_E = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      MD_START_E = 1'b0; MD_IS_DIV_E = 1'b0;
    end
    #1;
    n_checks++;
    if (md_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_pre got %b want 1", md_busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (md_busy !== 1'b0 || stall_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL mr_async got %b/%0d want 0/0",
               md_busy, stall_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    MD_START_E = 1'b1; MD_IS_DIV_E = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      MD_START_E = 1'b0;
      #2;
      n_checks++;
      if (md_busy !== (c <= 5)) begin
        n_fail++;
        $display("FAIL mr_mul_c%0d got %b want %b",
                 c, md_busy, c <= 5);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg_zero();
    test_branch();
    test_rt_m_stage();
    test_div_stall();
    test_mult_nostall();
    test_saturate();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
